wb_bram_banked: RTL and testbench

Single-clock, multi-bank successor to the wishbone-mapped BRAM. It provides N_BANKS independent user-side RAM banks of configurable width, all on the wishbone clock. The whole array is mapped into one wishbone slave window.
- Over the single bridge, the block adds byte-lane (wb_sel_i) writes, bank decoding with bus error on unmapped banks, and a valid-qualified user read pipeline.
- Sits between the wishbone interconnect and DSP capture/playback logic that shares the bus clock.

---
 rtl/wb_bram_banked.sv | 203 ++++++++++++++++++++
 tb/tb_wb_bram_banked.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_bram_banked.sv
// wb_bram_banked: N_BANKS independent user-side RAM banks, all mapped into a
// single wishbone slave window and all clocked by wb_clk_i.
// The wishbone port does 32-bit lane accesses with byte selects. Accesses to
// unmapped banks return wb_err_o. Each user port has a valid-qualified read
// pipeline of N_REGISTERS stages.
// Optional build macro: WB_BRAM_BANKED_WRITE_LOCK_EN adds wb_lock_i, which
// makes wishbone writes to a locked bank return wb_err_o without writing.
module wb_bram_banked #(
    parameter int N_BANKS        = 2,
    parameter int LOG_USER_WIDTH = 6,
    parameter int USER_ADDR_BITS = 9,
    parameter int N_REGISTERS    = 2,
    localparam int USER_WIDTH    = 1 << LOG_USER_WIDTH
) (
    input  logic                                 wb_clk_i,
    input  logic                                 wb_rst_i,
    input  logic                                 wb_cyc_i,
    input  logic                                 wb_stb_i,
    input  logic                                 wb_we_i,
    input  logic [31:0]                          wb_adr_i,
    input  logic [3:0]                           wb_sel_i,
    input  logic [31:0]                          wb_dat_i,
    output logic [31:0]                          wb_dat_o,
    output logic                                 wb_ack_o,
    output logic                                 wb_err_o,
`ifdef WB_BRAM_BANKED_WRITE_LOCK_EN
    input  logic [N_BANKS-1:0]                   wb_lock_i,
`endif
    input  logic [N_BANKS*USER_ADDR_BITS-1:0]    user_addr,
    input  logic [N_BANKS*USER_WIDTH-1:0]        user_din,
    input  logic [N_BANKS-1:0]                   user_we,
    input  logic [N_BANKS-1:0]                   user_re,
    output logic [N_BANKS*USER_WIDTH-1:0]        user_dout,
    output logic [N_BANKS-1:0]                   user_dout_vld
);

    localparam int LANE_BITS    = LOG_USER_WIDTH - 5;
    localparam int N_LANES      = 1 << LANE_BITS;
    localparam int LANE_W       = (LANE_BITS > 0) ? LANE_BITS : 1;
    localparam int WB_ADDR_BITS = USER_ADDR_BITS + LANE_BITS;
    localparam int BANK_BITS    = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;
    localparam int BANK_LSB     = WB_ADDR_BITS + 2;
    localparam int CNT_W        = (N_REGISTERS > 1) ? $clog2(N_REGISTERS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                      state, state_nxt;
    logic [CNT_W-1:0]            cnt, cnt_nxt;
    logic                        accept, respond;

    logic [WB_ADDR_BITS-1:0]     wb_word;
    logic [BANK_BITS-1:0]        wb_bank;
    logic [USER_ADDR_BITS-1:0]   wb_uaddr;
    logic [LANE_W-1:0]           wb_lane;
    logic                        wb_unmapped, wb_locked, wb_reject;

    logic                        req_we, req_err;
    logic [BANK_BITS-1:0]        req_bank;
    logic [LANE_W-1:0]           req_lane;
    logic [N_BANKS*USER_WIDTH-1:0] rd_flat;
    logic [31:0]                 rd_lane;
    logic                        unused_adr;

    // Byte address split: word within bank, bank index, lane within user word.
    assign wb_word     = wb_adr_i[WB_ADDR_BITS+1:2];
    assign wb_bank     = wb_adr_i[BANK_LSB+BANK_BITS-1:BANK_LSB];
    assign wb_uaddr    = USER_ADDR_BITS'(wb_word >> LANE_BITS);
    assign wb_lane     = LANE_W'(32'(wb_word) & (N_LANES - 1));
    assign wb_unmapped = (32'(wb_bank) >= N_BANKS);
    assign unused_adr  = ^{wb_adr_i[31:BANK_LSB+BANK_BITS], wb_adr_i[1:0]};

`ifdef WB_BRAM_BANKED_WRITE_LOCK_EN
    assign wb_locked = wb_we_i && !wb_unmapped && wb_lock_i[wb_bank];
`else
    assign wb_locked = 1'b0;
`endif
    assign wb_reject = wb_unmapped || wb_locked;

    // Transaction state register; reset drops any pending response.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state: accept only when idle, respond N_REGISTERS edges later, then
    // spend the response cycle busy so back-to-back strobes space out.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        respond   = 1'b0;
        case (state)
            S_IDLE: begin
                if (wb_cyc_i && wb_stb_i && !wb_rst_i) begin
                    accept    = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == CNT_W'(N_REGISTERS - 1)) begin
                    respond   = 1'b1;
                    state_nxt = S_RESP;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_RESP: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Remember what the accepted transaction needs at response time.
    always_ff @(posedge wb_clk_i) begin
        if (accept) begin
            req_we   <= wb_we_i;
            req_err  <= wb_reject;
            req_bank <= wb_bank;
            req_lane <= wb_lane;
        end
    end

    // Pick the addressed 32-bit lane from the captured bank word.
    always_comb begin
        rd_lane = '0;
        if (!req_err) begin
            rd_lane = rd_flat[int'(req_bank)*USER_WIDTH + int'(req_lane)*32 +: 32];
        end
    end

    // Response registers: one-cycle ack or err, read data only alongside ack.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= respond && !req_err;
            wb_err_o <= respond && req_err;
            wb_dat_o <= (respond && !req_err && !req_we) ? rd_lane : '0;
        end
    end

    for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
        logic [USER_WIDTH-1:0]     mem [2**USER_ADDR_BITS];
        logic [USER_WIDTH-1:0]     wb_rd;
        logic [USER_WIDTH-1:0]     user_rd [N_REGISTERS];
        logic [N_REGISTERS-1:0]    user_vld;
        logic [USER_ADDR_BITS-1:0] uaddr;
        logic                      sel;

        assign uaddr = user_addr[b*USER_ADDR_BITS +: USER_ADDR_BITS];
        assign sel   = (32'(wb_bank) == b);

        // RAM array, read-first on both ports; the user write is assigned
        // last so it wins every byte it overlaps with a wishbone write.
        always_ff @(posedge wb_clk_i) begin
            if (accept && sel) begin
                wb_rd <= mem[wb_uaddr];
                if (wb_we_i && !wb_reject) begin
                    for (int i = 0; i < 4; i++) begin
                        if (wb_sel_i[i]) begin
                            mem[wb_uaddr][int'(wb_lane)*32 + i*8 +: 8] <= wb_dat_i[i*8 +: 8];
                        end
                    end
                end
            end
            if (user_we[b]) begin
                mem[uaddr] <= user_din[b*USER_WIDTH +: USER_WIDTH];
            end
            if (user_re[b]) begin
                user_rd[0] <= mem[uaddr];
            end
            for (int s = 1; s < N_REGISTERS; s++) begin
                if (user_vld[s-1]) begin
                    user_rd[s] <= user_rd[s-1];
                end
            end
        end

        // User read valid pipeline, flushed by reset.
        always_ff @(posedge wb_clk_i) begin
            if (wb_rst_i) begin
                user_vld <= '0;
            end else begin
                user_vld[0] <= user_re[b];
                for (int s = 1; s < N_REGISTERS; s++) begin
                    user_vld[s] <= user_vld[s-1];
                end
            end
        end

        assign rd_flat[b*USER_WIDTH +: USER_WIDTH]   = wb_rd;
        assign user_dout[b*USER_WIDTH +: USER_WIDTH] = user_rd[N_REGISTERS-1];
        assign user_dout_vld[b]                      = user_vld[N_REGISTERS-1];
    end

endmodule

// File: tb/tb_wb_bram_banked.sv
// Directed bench for wb_bram_banked built with three banks so that bank index
// 3 is unmapped; the other parameters are left at their defaults.
module tb_wb_bram_banked;

    localparam int NB = 3;
    localparam int UW = 64;
    localparam int UA = 9;

    logic            clk = 1'b0;
    logic            rst;
    logic            wb_cyc, wb_stb, wb_we;
    logic [31:0]     wb_adr, wb_dat_w;
    logic [3:0]      wb_sel;
    logic [31:0]     wb_dat_r;
    logic            wb_ack, wb_err;
`ifdef WB_BRAM_BANKED_WRITE_LOCK_EN
    logic [NB-1:0]   wb_lock;
`endif
    logic [NB*UA-1:0] user_addr;
    logic [NB*UW-1:0] user_din;
    logic [NB-1:0]    user_we, user_re;
    logic [NB*UW-1:0] user_dout;
    logic [NB-1:0]    user_dout_vld;

    int errors = 0;
    int checks = 0;

    logic [31:0] rdat;
    logic        rack, rerr, after;
    int          lat, cnt;
    logic [63:0] udat;

    wb_bram_banked #(.N_BANKS(NB)) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .wb_cyc_i(wb_cyc),
        .wb_stb_i(wb_stb),
        .wb_we_i(wb_we),
        .wb_adr_i(wb_adr),
        .wb_sel_i(wb_sel),
        .wb_dat_i(wb_dat_w),
        .wb_dat_o(wb_dat_r),
        .wb_ack_o(wb_ack),
        .wb_err_o(wb_err),
`ifdef WB_BRAM_BANKED_WRITE_LOCK_EN
        .wb_lock_i(wb_lock),
`endif
        .user_addr(user_addr),
        .user_din(user_din),
        .user_we(user_we),
        .user_re(user_re),
        .user_dout(user_dout),
        .user_dout_vld(user_dout_vld)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic user_write(input int bank, input logic [8:0] addr, input logic [63:0] data);
        user_addr[bank*UA +: UA] = addr;
        user_din[bank*UW +: UW]  = data;
        user_we[bank] = 1'b1;
        tick();
        user_we[bank] = 1'b0;
    endtask

    // lat counts edges from the request edge (inclusive) until valid is seen.
    task automatic user_read(input int bank, input logic [8:0] addr,
                             output logic [63:0] data, output int l, output logic vld_after);
        user_addr[bank*UA +: UA] = addr;
        user_re[bank] = 1'b1;
        l = 0;
        data = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            l++;
            user_re[bank] = 1'b0;
            if (user_dout_vld[bank]) begin
                data = user_dout[bank*UW +: UW];
                break;
            end
        end
        tick();
        vld_after = user_dout_vld[bank];
    endtask

    // lat counts edges after the acceptance edge until ack/err is seen.
    task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                           input logic [31:0] dat, output logic [31:0] rd,
                           output logic ack, output logic err, output int l,
                           output logic resp_after);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_adr = adr; wb_we = we; wb_sel = sel; wb_dat_w = dat;
        tick();
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_sel = '0; wb_dat_w = '0;
        l = 0; ack = 1'b0; err = 1'b0; rd = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            l++;
            if (wb_ack || wb_err) begin
                ack = wb_ack; err = wb_err; rd = wb_dat_r;
                break;
            end
        end
        tick();
        resp_after = wb_ack || wb_err;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_adr = '0; wb_sel = '0; wb_dat_w = '0;
`ifdef WB_BRAM_BANKED_WRITE_LOCK_EN
        wb_lock = '0;
`endif
        user_addr = '0; user_din = '0; user_we = '0; user_re = '0;
        tick(); tick(); tick();
        check("rst_ack", 64'(wb_ack), 64'h0);
        check("rst_err", 64'(wb_err), 64'h0);
        check("rst_dat", 64'(wb_dat_r), 64'h0);
        check("rst_vld", 64'(user_dout_vld), 64'h0);
        rst = 1'b0;
        tick();

        // User write, wishbone reads of both lanes.
        user_write(0, 9'd5, 64'h1122334455667788);
        wb_xfer(32'h28, 1'b0, 4'hF, 32'h0, rdat, rack, rerr, lat, after);
        check("rd28_ack", 64'(rack), 64'h1);
        check("rd28_err", 64'(rerr), 64'h0);
        check("rd28_latency", 64'(lat), 64'd2);
        check("rd28_data", 64'(rdat), 64'h55667788);
        check("rd28_one_cycle", 64'(after), 64'h0);
        check("rd28_dat_idle", 64'(wb_dat_r), 64'h0);
        wb_xfer(32'h2C, 1'b0, 4'hF, 32'h0, rdat, rack, rerr, lat, after);
        check("rd2c_data", 64'(rdat), 64'h11223344);

        // Byte-lane writes into bank 1, both lanes.
        user_write(1, 9'd0, 64'h0);
        wb_xfer(32'h1000, 1'b1, 4'b0101, 32'hAABBCCDD, rdat, rack, rerr, lat, after);
        check("wr1000_ack", 64'(rack), 64'h1);
        user_read(1, 9'd0, udat, lat, after);
        check("sel0101_data", udat, 64'h0000000000BB00DD);
        check("user_rd_latency", 64'(lat), 64'd2);
        check("user_vld_one_cycle", 64'(after), 64'h0);
        wb_xfer(32'h1004, 1'b1, 4'b1000, 32'h12345678, rdat, rack, rerr, lat, after);
        user_read(1, 9'd0, udat, lat, after);
        check("sel1000_lane1", udat, 64'h1200000000BB00DD);

        // Bank 2 is mapped; bank 3 is not.
        wb_xfer(32'h2008, 1'b1, 4'hF, 32'h5A5A5A5A, rdat, rack, rerr, lat, after);
        check("wr2008_ack", 64'(rack), 64'h1);
        wb_xfer(32'h2008, 1'b0, 4'hF, 32'h0, rdat, rack, rerr, lat, after);
        check("rd2008_data", 64'(rdat), 64'h5A5A5A5A);
        user_write(0, 9'd0, 64'hCAFEF00D87654321);
        wb_xfer(32'h3000, 1'b1, 4'hF, 32'hDEADBEEF, rdat, rack, rerr, lat, after);
        check("unmapped_wr_err", 64'(rerr), 64'h1);
        check("unmapped_wr_ack", 64'(rack), 64'h0);
        check("unmapped_wr_dat", 64'(rdat), 64'h0);
        check("unmapped_wr_latency", 64'(lat), 64'd2);
        check("unmapped_err_one_cycle", 64'(after), 64'h0);
        wb_xfer(32'h3004, 1'b0, 4'hF, 32'h0, rdat, rack, rerr, lat, after);
        check("unmapped_rd_err", 64'(rerr), 64'h1);
        check("unmapped_rd_dat", 64'(rdat), 64'h0);
        wb_xfer(32'h0, 1'b0, 4'hF, 32'h0, rdat, rack, rerr, lat, after);
        check("bank0_unchanged", 64'(rdat), 64'h87654321);
        user_read(1, 9'd0, udat, lat, after);
        check("bank1_unchanged", udat, 64'h1200000000BB00DD);

        // Same-edge wishbone and user write to bank 0 addr 0: user wins.
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_adr = 32'h0; wb_we = 1'b1; wb_sel = 4'hF;
        wb_dat_w = 32'hFFFFFFFF;
        user_addr[0 +: UA] = 9'd0; user_din[0 +: UW] = 64'h0123456789ABCDEF; user_we[0] = 1'b1;
        tick();
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; user_we[0] = 1'b0;
        rack = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (wb_ack) begin
                rack = 1'b1;
                break;
            end
        end
        check("collision_ack", 64'(rack), 64'h1);
        tick();
        wb_xfer(32'h0, 1'b0, 4'hF, 32'h0, rdat, rack, rerr, lat, after);
        check("collision_lane0", 64'(rdat), 64'h89ABCDEF);
        wb_xfer(32'h4, 1'b0, 4'hF, 32'h0, rdat, rack, rerr, lat, after);
        check("collision_lane1", 64'(rdat), 64'h01234567);

        // User read and write together return the old word.
        user_write(2, 9'd3, 64'h1111);
        user_din[2*UW +: UW] = 64'h2222;
        user_we[2] = 1'b1;
        user_read(2, 9'd3, udat, lat, after);
        check("user_read_first", udat, 64'h1111);
        user_read(2, 9'd3, udat, lat, after);
        check("user_new_data", udat, 64'h2222);

        // Reset with a read pending and strobe held.
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h28; wb_sel = 4'hF;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_flush_ack", 64'(wb_ack), 64'h0);
        check("rst_flush_err", 64'(wb_err), 64'h0);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            cnt++;
            if (wb_ack) break;
        end
        check("post_rst_first_ack", 64'(cnt), 64'd3);
        check("post_rst_data", 64'(wb_dat_r), 64'h55667788);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            cnt++;
            if (wb_ack) break;
        end
        check("held_stb_spacing", 64'(cnt), 64'd4);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        tick(); tick();
        check("held_stb_released", 64'(wb_ack), 64'h0);

        // Reset flushes a user read in flight; RAM contents survive.
        user_addr[0 +: UA] = 9'd5;
        user_re[0] = 1'b1;
        tick();
        user_re[0] = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_flush_vld_a", 64'(user_dout_vld), 64'h0);
        tick();
        check("rst_flush_vld_b", 64'(user_dout_vld), 64'h0);
        user_read(0, 9'd5, udat, lat, after);
        check("ram_survives_rst", udat, 64'h1122334455667788);

`ifdef WB_BRAM_BANKED_WRITE_LOCK_EN
        // Locked bank rejects wishbone writes but not reads.
        wb_lock = 3'b010;
        wb_xfer(32'h1004, 1'b1, 4'hF, 32'h99999999, rdat, rack, rerr, lat, after);
        check("locked_wr_err", 64'(rerr), 64'h1);
        check("locked_wr_ack", 64'(rack), 64'h0);
        user_read(1, 9'd0, udat, lat, after);
        check("locked_data_kept", udat, 64'h1200000000BB00DD);
        wb_xfer(32'h1004, 1'b0, 4'hF, 32'h0, rdat, rack, rerr, lat, after);
        check("locked_rd_data", 64'(rdat), 64'h12000000);
        wb_xfer(32'h0004, 1'b1, 4'hF, 32'h77777777, rdat, rack, rerr, lat, after);
        check("unlocked_wr_ack", 64'(rack), 64'h1);
        wb_xfer(32'h0004, 1'b0, 4'hF, 32'h0, rdat, rack, rerr, lat, after);
        check("unlocked_wr_data", 64'(rdat), 64'h77777777);
        wb_lock = '0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
